// File: rtl/fp_acc_seq_if.sv
// Source stream and fp32 adder handshake bundle for the accumulation controller.
interface fp_acc_seq_if;
  logic        d_valid;
  logic [31:0] d_in;
  logic        d_ready;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_r_i;
  logic [31:0] add_res;
  logic        add_r_o;

  // source + adder side
  modport master (
    output d_valid, d_in, add_res, add_r_o,
    input  d_ready, add_a, add_b, add_r_i
  );

  // controller side
  modport slave (
    input  d_valid, d_in, add_res, add_r_o,
    output d_ready, add_a, add_b, add_r_i
  );
endinterface

// File: rtl/fp_acc_seq.sv
// Sums a stream of len fp32 operands by sequencing one external fp32 adder.
// The first operand seeds the accumulator; each later operand is sent to the
// adder with the running sum and the result is fed back. No fp math here.
module fp_acc_seq #(
  parameter int N_MAX = 16,
  parameter int CNT_W = 5,
  parameter int FLUSH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  fp_acc_seq_if.slave      bus,
  output logic [31:0]      sum,
  output logic             done,
  output logic             busy
);
  localparam int FW = $clog2(FLUSH + 1);
  localparam logic [CNT_W-1:0] LEN_MAX    = CNT_W'(N_MAX);
  localparam logic [FW-1:0]    FLUSH_INIT = FW'(FLUSH);

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_LOAD, S_FETCH, S_WAIT, S_DONE
  } state_t;

  state_t           state, state_n;
  logic [FW-1:0]    flush_cnt;
  logic [CNT_W-1:0] rem, rem_n;
  logic [31:0]      acc, acc_n;
  logic             hs;

  assign hs   = bus.d_valid && bus.d_ready;
  assign busy = (state != S_IDLE);

  // state register; reset lands in FLUSH so stale adder results drain out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FLUSH;
    else        state <= state_n;
  end

  // next state plus next accumulator / remaining count
  always_comb begin
    state_n = state;
    acc_n   = acc;
    rem_n   = rem;
    unique case (state)
      S_FLUSH: if (flush_cnt == '0) state_n = S_IDLE;
      S_IDLE: if (start) begin
        acc_n   = '0;
        rem_n   = (len > LEN_MAX) ? LEN_MAX : len;
        state_n = (len == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: if (hs) begin
        acc_n   = bus.d_in;
        rem_n   = rem - CNT_W'(1);
        state_n = (rem == CNT_W'(1)) ? S_DONE : S_FETCH;
      end
      S_FETCH: if (hs) begin
        rem_n   = rem - CNT_W'(1);
        state_n = S_WAIT;
      end
      // add_r_o is only honoured here, so stray results elsewhere are dropped
      S_WAIT: if (bus.add_r_o) begin
        acc_n   = bus.add_res;
        state_n = (rem == '0) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_FLUSH;
    endcase
  end

  // datapath and registered outputs; done/sum load on entry to DONE so the
  // pulse and the value are visible together for the DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt   <= FLUSH_INIT;
      rem         <= '0;
      acc         <= '0;
      sum         <= '0;
      done        <= 1'b0;
      bus.d_ready <= 1'b0;
      bus.add_a   <= '0;
      bus.add_b   <= '0;
      bus.add_r_i <= 1'b0;
    end else begin
      acc         <= acc_n;
      rem         <= rem_n;
      bus.d_ready <= (state_n == S_LOAD) || (state_n == S_FETCH);
      done        <= (state_n == S_DONE);
      if (state_n == S_DONE) sum <= acc_n;
      if (state == S_FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - FW'(1);
      // request held with stable operands through WAIT; dropped on the r_o
      // edge so the adder, re-arming a cycle later, never sees a repeat
      if (state == S_FETCH && hs) begin
        bus.add_a   <= acc;
        bus.add_b   <= bus.d_in;
        bus.add_r_i <= 1'b1;
      end else if (state == S_WAIT && bus.add_r_o) begin
        bus.add_r_i <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp_acc_seq.sv
// Directed bench for fp_acc_seq with a table-driven fixed-latency adder model.
module tb_fp_acc_seq;
  localparam int N_MAX = 16;
  localparam int CNT_W = 5;
  localparam int FLUSH = 8;
  localparam int LAT   = 3;

  localparam logic [31:0] F1  = 32'h3F800000;
  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F3  = 32'h40400000;
  localparam logic [31:0] F4  = 32'h40800000;
  localparam logic [31:0] F6  = 32'h40C00000;
  localparam logic [31:0] F10 = 32'h41200000;
  localparam logic [31:0] FM3 = 32'hC0400000;
  localparam logic [31:0] FPI = 32'h40490FDB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_main = 1'b0;
  logic start_noise = 1'b0;
  logic start;
  logic [CNT_W-1:0] len = '0;
  logic [31:0] sum;
  logic done, busy;

  fp_acc_seq_if bus();

  assign start = start_main | start_noise;
  always #5 clk = ~clk;

  fp_acc_seq #(.N_MAX(N_MAX), .CNT_W(CNT_W), .FLUSH(FLUSH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .bus(bus), .sum(sum), .done(done), .busy(busy)
  );

  // hand-computed fp32 sums for the operand pairs used below
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {F1, F2}:  return F3;
      {F3, F3}:  return F6;
      {F6, F4}:  return F10;
      {F2, F2}:  return F4;
      {F3, FM3}: return 32'h00000000;
      default:   return 32'h7FC00000;
    endcase
  endfunction

  // adder model: no reset, LAT cycles to result, re-arms one cycle after r_o
  logic m_busy = 0, m_rearm = 0, m_ro = 0, inj_ro = 0;
  logic [31:0] m_res = '0, m_a = '0, m_b = '0, inj_res = '0;
  int m_cnt = 0;
  assign bus.add_r_o = m_ro | inj_ro;
  assign bus.add_res = inj_ro ? inj_res : m_res;

  always @(posedge clk) begin
    m_ro <= 1'b0;
    if (m_busy) begin
      if (m_cnt == 1) begin
        m_ro <= 1'b1; m_res <= fadd(m_a, m_b); m_busy <= 1'b0; m_rearm <= 1'b1;
      end else m_cnt <= m_cnt - 1;
    end else if (m_rearm) m_rearm <= 1'b0;
    else if (bus.add_r_i) begin
      m_a <= bus.add_a; m_b <= bus.add_b; m_cnt <= LAT; m_busy <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // start pulses injected while the controller is busy
  logic noise_en = 1'b0;
  always @(negedge clk) start_noise <= noise_en && busy && (cyc % 3 == 0);

  // protocol monitors
  int done_cnt = 0, ro_cyc = 0, done_cyc = 0, req_cnt = 0, rdy_hi = 0;
  int stab_err = 0, ri_late = 0;
  logic prev_ri = 0, prev_ro = 0;
  logic [31:0] prev_a = '0, prev_b = '0;
  logic [63:0] reqq[$];

  always @(negedge clk) begin
    if (bus.add_r_o) ro_cyc = cyc;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (bus.d_ready) rdy_hi++;
    if (bus.add_r_i && !prev_ri) begin req_cnt++; reqq.push_back({bus.add_a, bus.add_b}); end
    if (bus.add_r_i && prev_ri && (bus.add_a != prev_a || bus.add_b != prev_b)) stab_err++;
    if (prev_ro && prev_ri && bus.add_r_i) ri_late++;
    prev_ri = bus.add_r_i; prev_ro = bus.add_r_o;
    prev_a = bus.add_a;    prev_b = bus.add_b;
  end

  int n_chk = 0, n_fail = 0;
  int s_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pop_req();
    if (reqq.size() == 0) return '1;
    return reqq.pop_front();
  endfunction

  task automatic chk_req(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    e = pop_req();
    chk({tag, "_a"}, e[63:32], a);
    chk({tag, "_b"}, e[31:0], b);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic start_job(input int l);
    @(negedge clk);
    len = CNT_W'(l); start_main = 1'b1; s_cyc = cyc;
    @(negedge clk);
    start_main = 1'b0;
  endtask

  // offer one operand after gap idle cycles; caller sits at a negedge
  task automatic push(input logic [31:0] v, input int gap, output int gap_lo, output logic rdy0);
    int t;
    gap_lo = 0;
    repeat (gap) begin @(negedge clk); if (!bus.d_ready) gap_lo++; end
    bus.d_valid = 1'b1; bus.d_in = v; rdy0 = bus.d_ready;
    t = 0;
    while (!bus.d_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("push_timeout", 32'(t), 32'd0);
    @(negedge clk);
    bus.d_valid = 1'b0; bus.d_in = '0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("done_timeout", 32'(t), 32'd0);
  endtask

  task automatic count_flush(input string tag);
    int bc;
    bc = 0;
    while (busy && bc < 100) begin
      @(negedge clk);
      if (busy) bc++;
      if (bc == 4) start_main = 1'b0;
    end
    chk(tag, 32'(bc), 32'(FLUSH));
  endtask

  int d0, r0, k0, g1, g2, g3;
  logic k1, k2, k3;

  initial begin
    bus.d_valid = 1'b0; bus.d_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_sum", sum, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_add_r_i", 32'(bus.add_r_i), 32'h0);
    chk("rst_d_ready", 32'(bus.d_ready), 32'h0);
    chk("rst_add_a", bus.add_a, 32'h0);
    chk("rst_add_b", bus.add_b, 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);

    // release with start held through early FLUSH: must be ignored
    rst_n = 1'b1; start_main = 1'b1; len = CNT_W'(4);
    count_flush("flush_busy_cycles");
    start_main = 1'b0;
    settle(3);
    chk("flush_start_ignored", 32'(busy), 32'h0);
    chk("flush_no_done", 32'(done_cnt), 32'h0);

    // basic sum 1+2+3+4
    d0 = done_cnt; r0 = req_cnt;
    start_job(4);
    push(F1, 0, g1, k1); push(F2, 0, g1, k1); push(F3, 0, g1, k1); push(F4, 0, g1, k1);
    wait_done();
    chk("basic_sum", sum, F10);
    settle(3);
    chk("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("basic_req_cnt", 32'(req_cnt - r0), 32'd3);
    chk_req("basic_req0", F1, F2);
    chk_req("basic_req1", F3, F3);
    chk_req("basic_req2", F6, F4);
    chk("basic_ro_to_done", 32'(done_cyc - ro_cyc), 32'd1);

    // len == 0
    d0 = done_cnt; r0 = req_cnt; k0 = rdy_hi;
    start_job(0);
    wait_done();
    settle(3);
    chk("len0_sum", sum, 32'h0);
    chk("len0_latency", 32'((done_cyc - s_cyc) >= 1 && (done_cyc - s_cyc) <= 2), 32'd1);
    chk("len0_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("len0_no_req", 32'(req_cnt - r0), 32'd0);
    chk("len0_no_ready", 32'(rdy_hi - k0), 32'd0);

    // len == 1
    d0 = done_cnt; r0 = req_cnt;
    start_job(1);
    push(FPI, 0, g1, k1);
    chk("len1_done_lat", 32'(done), 32'd1);
    chk("len1_sum", sum, FPI);
    settle(3);
    chk("len1_no_req", 32'(req_cnt - r0), 32'd0);
    chk("len1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // backpressure with start pulses while busy
    d0 = done_cnt; r0 = req_cnt;
    noise_en = 1'b1;
    start_job(3);
    push(F1, 8, g1, k1); push(F2, 8, g2, k2); push(F3, 8, g3, k3);
    wait_done();
    chk("bp_sum", sum, F6);
    noise_en = 1'b0;
    settle(6);
    chk("bp_gap1_ready", 32'(g1), 32'd0);
    chk("bp_gap2_ready", 32'(g2), 32'd0);
    chk("bp_ready_waiting", 32'({k1, k2, k3}), 32'b111);
    chk("bp_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("bp_req_cnt", 32'(req_cnt - r0), 32'd2);
    chk_req("bp_req0", F1, F2);
    chk_req("bp_req1", F3, F3);
    chk("bp_busy_after", 32'(busy), 32'd0);

    // reset while a request is outstanding
    d0 = done_cnt;
    start_job(3);
    push(F1, 0, g1, k1); push(F2, 0, g1, k1);
    chk("wr_ri_before", 32'(bus.add_r_i), 32'd1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("wr_ri_async", 32'(bus.add_r_i), 32'd0);
    chk("wr_busy", 32'(busy), 32'd1);
    chk_req("wr_req0", F1, F2);
    @(negedge clk);
    rst_n = 1'b1;
    count_flush("wr_flush_cycles");
    chk("wr_stale_no_done", 32'(done_cnt - d0), 32'd0);
    chk("wr_sum_cleared", sum, 32'h0);
    @(negedge clk);
    inj_res = 32'h44800000; inj_ro = 1'b1;
    @(negedge clk);
    inj_ro = 1'b0;
    settle(3);
    chk("wr_idle_ro_busy", 32'(busy), 32'd0);
    chk("wr_idle_ro_done", 32'(done_cnt - d0), 32'd0);
    chk("wr_idle_ro_sum", sum, 32'h0);
    start_job(2);
    push(F2, 0, g1, k1); push(F2, 0, g1, k1);
    wait_done();
    chk("wr_follow_sum", sum, F4);
    settle(3);
    chk_req("wr_follow_req", F2, F2);

    // negative operands: result is the adder word as returned
    d0 = done_cnt;
    start_job(2);
    push(F3, 0, g1, k1); push(FM3, 0, g1, k1);
    wait_done();
    chk("neg_sum", sum, 32'h00000000);
    settle(4);
    chk("neg_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk_req("neg_req", F3, FM3);

    chk("stable_in_wait", 32'(stab_err), 32'd0);
    chk("ri_drop_on_ro", 32'(ri_late), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
